multicycle_sequencer: RTL and testbench
=======================================

MULTICYCLE_SEQUENCER -- requirements
Module: multicycle_sequencer

Interface
REQ-001 Parameter HALT_OP, default 5'b11111, opcode that stops the processor.
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 run  input  1  level; 1 = free-running execution, 0 = paused/single-step mode.
REQ-005 step_req  input  1  one-cycle pulse; requests execution of exactly one instruction while run=0.
REQ-006 opcode  input  5  instr[31:27] of the currently latched instruction.
REQ-007 mem_read, mem_write, reg_write  input  1 each  decoded control lines for the latched instruction.
REQ-008 imem_en  output  1  instruction memory enable.
REQ-009 ir_we  output  1  latch instruction memory output into the instruction register.
REQ-010 alu_en  output  1  ALU evaluation/flag capture enable.
REQ-011 dmem_en, dmem_we  output  1 each  data memory enable and write enable.
REQ-012 rf_we  output  1  register file write enable (gated reg_write).
REQ-013 pc_we  output  1  program counter load enable.
REQ-014 retire  output  1  one-cycle pulse when an instruction completes.
REQ-015 halted  output  1  level; high in HALT state.
REQ-016 cycle_cnt, instr_cnt  output  32 each  free-running cycle count and retired-instruction count.

Function
REQ-017 FSM states SHALL be IDLE, FETCH, FETCH_WAIT, DECODE, EXEC, MEM, MEM_WAIT, WB, HALT.
REQ-018 IDLE -> FETCH when run=1, or when run=0 and a step token is held; otherwise stay in IDLE.
REQ-019 A step_req while run=0 SHALL set a one-deep step token; token is cleared on entering FETCH; further step_req pulses while token set or instruction in flight are dropped.
REQ-020 FETCH asserts imem_en; FETCH_WAIT asserts imem_en and ir_we (one-cycle BRAM latency); then DECODE.
REQ-021 DECODE: if opcode==HALT_OP -> HALT with no pc_we and no retire; else -> EXEC.
REQ-022 EXEC asserts alu_en; next: MEM if mem_read|mem_write; else WB if reg_write; else retire in EXEC.
REQ-023 MEM asserts dmem_en, and dmem_we iff mem_write; store retires in MEM; load -> MEM_WAIT.
REQ-024 MEM_WAIT asserts dmem_en (read data valid next cycle) -> WB.
REQ-025 WB asserts rf_we iff reg_write (covers load and link writes to r31); retires in WB.
REQ-026 In the retiring state pc_we=1 and retire=1 for exactly one cycle; next state FETCH if run=1, else IDLE.
REQ-027 Latencies: branch/jump without link 4 cycles, ALU and store 5, load 7, FETCH to next FETCH under run=1.
REQ-028 pc_we, rf_we, dmem_we SHALL never be asserted outside the states above; all outputs are registered-state decodes (Moore).
REQ-029 Clearing run mid-instruction SHALL NOT abort it; the instruction completes and the FSM parks in IDLE.
REQ-030 HALT is absorbing; only reset leaves it; halted=1; cycle_cnt stops, instr_cnt holds.
REQ-031 cycle_cnt increments every cycle outside IDLE and HALT; instr_cnt increments on retire; both wrap modulo 2^32.

Reset
REQ-032 On reset=1 at a clock edge: state=IDLE, step token=0, cycle_cnt=0, instr_cnt=0; all enables, retire and halted=0 in the following cycle.
REQ-033 Reset mid-instruction SHALL suppress any pending pc_we/rf_we/dmem_we from that cycle onward.

Structure
REQ-034 State encoding enum, HALT_OP default and the 5-bit opcode width SHALL live in the shared processor package.
REQ-035 The two 32-bit counters SHALL be one reused sub-module, perf_counter (enable, synchronous clear, wrap).

Verification
REQ-036 reset, run=1, ALU instruction with reg_write=1 -> pc_we/retire at cycle 5, rf_we only in WB, instr_cnt=1.
REQ-037 Load (mem_read=1, reg_write=1) -> dmem_en in cycles 5-6, dmem_we=0, rf_we in cycle 7, cycle_cnt=7 at retire.
REQ-038 Store (mem_write=1) -> dmem_we=1 in cycle 5 only, rf_we never asserted, retire in cycle 5.
REQ-039 run=0, two step_req pulses one cycle apart -> exactly one instruction retires, FSM returns to IDLE, instr_cnt=1.
REQ-040 opcode=5'b11111 -> HALT after DECODE, halted=1, pc_we never pulses, counters frozen over 20 cycles; reset returns to IDLE.
REQ-041 Reset asserted in MEM of a store -> dmem_we=0 next cycle, counters 0, state IDLE.

Source files
------------

// File: rtl/multicycle_sequencer_pkg.sv
// Shared processor package for the multicycle sequencer.
// Holds the sequencer state encoding, the opcode width, the default halt
// opcode and the width of the performance counters, so every file that
// touches control state agrees on the same definitions.
package multicycle_sequencer_pkg;

  localparam int OPCODE_W = 5;
  localparam int COUNT_W  = 32;

  localparam logic [OPCODE_W-1:0] HALT_OP_DEFAULT = 5'b11111;

  typedef enum logic [3:0] {
    IDLE,
    FETCH,
    FETCH_WAIT,
    DECODE,
    EXEC,
    MEM,
    MEM_WAIT,
    WB,
    HALT
  } state_t;

endpackage

// File: rtl/multicycle_sequencer_perf_counter.sv
// perf_counter: free-running performance counter with enable, synchronous
// clear and natural wrap at 2^WIDTH.
// Ports:
//   i_clk    - system clock, rising edge
//   i_clear  - synchronous clear, wins over enable
//   i_en     - count enable, one increment per enabled cycle
//   o_count  - current count value
module perf_counter #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_clear,
  input  logic             i_en,
  output logic [WIDTH-1:0] o_count
);

  logic [WIDTH-1:0] r_count;

  // Clear has priority; the add simply rolls over at the top of the range.
  always_ff @(posedge i_clk) begin
    if (i_clear) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/multicycle_sequencer.sv
// multicycle_sequencer: control sequencer for a multicycle processor.
// Walks each instruction through FETCH, FETCH_WAIT, DECODE, EXEC and, as
// needed, MEM/MEM_WAIT/WB, retiring it in the last state it needs.
// Supports free-running (i_run=1) and single-step (i_run=0 + i_step_req).
// Ports:
//   i_clk, i_reset            - clock, synchronous active-high reset
//   i_run                     - 1 = free run, 0 = paused / single step
//   i_step_req                - one-cycle request for one instruction
//   i_opcode                  - opcode of the latched instruction
//   i_mem_read/i_mem_write    - decoded memory access of the instruction
//   i_reg_write               - decoded register write of the instruction
//   o_imem_en, o_ir_we        - instruction memory enable / IR load
//   o_alu_en                  - ALU evaluate / flag capture
//   o_dmem_en, o_dmem_we      - data memory enable / write enable
//   o_rf_we                   - register file write enable
//   o_pc_we, o_retire         - PC load and retire pulse
//   o_halted                  - high while halted
//   o_cycle_cnt, o_instr_cnt  - active-cycle and retired-instruction counts
module multicycle_sequencer
  import multicycle_sequencer_pkg::*;
#(
  parameter logic [OPCODE_W-1:0] HALT_OP = HALT_OP_DEFAULT
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_run,
  input  logic                i_step_req,
  input  logic [OPCODE_W-1:0] i_opcode,
  input  logic                i_mem_read,
  input  logic                i_mem_write,
  input  logic                i_reg_write,
  output logic                o_imem_en,
  output logic                o_ir_we,
  output logic                o_alu_en,
  output logic                o_dmem_en,
  output logic                o_dmem_we,
  output logic                o_rf_we,
  output logic                o_pc_we,
  output logic                o_retire,
  output logic                o_halted,
  output logic [COUNT_W-1:0]  o_cycle_cnt,
  output logic [COUNT_W-1:0]  o_instr_cnt
);

  state_t r_state;
  state_t w_nextState;
  logic   r_stepToken;
  logic   w_retire;
  logic   w_cycleEn;

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // One-deep step token. It can only be captured while parked in IDLE,
  // so requests arriving mid-instruction are dropped, and it is consumed
  // by the IDLE -> FETCH transition. The clear branch is listed first so a
  // request arriving in the same cycle the token is consumed is dropped too.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_stepToken <= 1'b0;
    end else if (r_state == IDLE && w_nextState == FETCH) begin
      r_stepToken <= 1'b0;
    end else if (i_step_req && !i_run && r_state == IDLE) begin
      r_stepToken <= 1'b1;
    end
  end

  // Next-state and output decode. Outputs depend only on the current state
  // and the decoded lines of the already-latched instruction, never on
  // anything that changes within the instruction. The retiring state is
  // whichever state the instruction finishes in; the shared tail below
  // applies the PC update and chooses FETCH or IDLE from i_run, which is
  // only consulted here so clearing it mid-instruction never aborts.
  always_comb begin
    w_nextState = r_state;
    w_retire    = 1'b0;
    o_imem_en   = 1'b0;
    o_ir_we     = 1'b0;
    o_alu_en    = 1'b0;
    o_dmem_en   = 1'b0;
    o_dmem_we   = 1'b0;
    o_rf_we     = 1'b0;
    o_halted    = 1'b0;

    unique case (r_state)
      IDLE: begin
        if (i_run || r_stepToken) begin
          w_nextState = FETCH;
        end
      end
      FETCH: begin
        o_imem_en   = 1'b1;
        w_nextState = FETCH_WAIT;
      end
      FETCH_WAIT: begin
        o_imem_en   = 1'b1;
        o_ir_we     = 1'b1;
        w_nextState = DECODE;
      end
      DECODE: begin
        w_nextState = (i_opcode == HALT_OP) ? HALT : EXEC;
      end
      EXEC: begin
        o_alu_en = 1'b1;
        if (i_mem_read || i_mem_write) begin
          w_nextState = MEM;
        end else if (i_reg_write) begin
          w_nextState = WB;
        end else begin
          w_retire = 1'b1;
        end
      end
      MEM: begin
        o_dmem_en = 1'b1;
        o_dmem_we = i_mem_write;
        if (i_mem_read) begin
          w_nextState = MEM_WAIT;
        end else begin
          w_retire = 1'b1;
        end
      end
      MEM_WAIT: begin
        o_dmem_en   = 1'b1;
        w_nextState = WB;
      end
      WB: begin
        o_rf_we  = i_reg_write;
        w_retire = 1'b1;
      end
      HALT: begin
        o_halted = 1'b1;
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase

    if (w_retire) begin
      w_nextState = i_run ? FETCH : IDLE;
    end
  end

  assign o_pc_we  = w_retire;
  assign o_retire = w_retire;

  // Only cycles spent working on an instruction are counted.
  assign w_cycleEn = (r_state != IDLE) && (r_state != HALT);

  perf_counter #(.WIDTH(COUNT_W)) u_cycleCnt (
    .i_clk   (i_clk),
    .i_clear (i_reset),
    .i_en    (w_cycleEn),
    .o_count (o_cycle_cnt)
  );

  perf_counter #(.WIDTH(COUNT_W)) u_instrCnt (
    .i_clk   (i_clk),
    .i_clear (i_reset),
    .i_en    (w_retire),
    .o_count (o_instr_cnt)
  );

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Testbench for multicycle_sequencer: table-driven instruction classes plus
// directed sequences for single-step, halt, run-clear and reset-in-MEM.
module tb_multicycle_sequencer;

  logic        clk;
  logic        reset;
  logic        run;
  logic        stepReq;
  logic [4:0]  opcode;
  logic        memRead;
  logic        memWrite;
  logic        regWrite;
  logic        imemEn;
  logic        irWe;
  logic        aluEn;
  logic        dmemEn;
  logic        dmemWe;
  logic        rfWe;
  logic        pcWe;
  logic        retire;
  logic        halted;
  logic [31:0] cycleCnt;
  logic [31:0] instrCnt;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [4:0] op;
    logic       mr;
    logic       mw;
    logic       rw;
    int         lat;
    logic [7:0] imemMask;
    logic [7:0] irMask;
    logic [7:0] aluMask;
    logic [7:0] dmemEnMask;
    logic [7:0] dmemWeMask;
    logic [7:0] rfWeMask;
    logic [7:0] pcWeMask;
  } vec_t;

  vec_t vecs[5];

  multicycle_sequencer dut (
    .i_clk       (clk),
    .i_reset     (reset),
    .i_run       (run),
    .i_step_req  (stepReq),
    .i_opcode    (opcode),
    .i_mem_read  (memRead),
    .i_mem_write (memWrite),
    .i_reg_write (regWrite),
    .o_imem_en   (imemEn),
    .o_ir_we     (irWe),
    .o_alu_en    (aluEn),
    .o_dmem_en   (dmemEn),
    .o_dmem_we   (dmemWe),
    .o_rf_we     (rfWe),
    .o_pc_we     (pcWe),
    .o_retire    (retire),
    .o_halted    (halted),
    .o_cycle_cnt (cycleCnt),
    .o_instr_cnt (instrCnt)
  );

  // 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case something wedges the main sequence.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Advance one clock and settle just past the edge for sampling/driving.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reset with the given instruction lines held, then release with run set.
  task automatic applyStimulus(input logic [4:0] op, input logic mr,
                               input logic mw, input logic rw,
                               input logic runLevel);
    reset    = 1'b1;
    run      = 1'b0;
    stepReq  = 1'b0;
    opcode   = op;
    memRead  = mr;
    memWrite = mw;
    regWrite = rw;
    tick();
    reset = 1'b0;
    run   = runLevel;
  endtask

  // Bounded wait for the first FETCH cycle.
  task automatic waitFetch(input string name);
    int n;
    n = 0;
    while (!imemEn && n < 10) begin
      tick();
      n++;
    end
    if (!imemEn) checkOutput(name, 32'd0, 32'd1);
  endtask

  function automatic logic [8:0] outVec();
    return {imemEn, irWe, aluEn, dmemEn, dmemWe, rfWe, pcWe, retire, halted};
  endfunction

  initial begin
    int retires;
    int pcSeen;
    logic [8:0] exp;

    // ALU (opcode one below halt), branch, jump-and-link, load, store.
    vecs[0] = '{5'b11110, 1'b0, 1'b0, 1'b1, 5, 8'b00000011, 8'b00000010,
                8'b00001000, 8'b00000000, 8'b00000000, 8'b00010000, 8'b00010000};
    vecs[1] = '{5'b00100, 1'b0, 1'b0, 1'b0, 4, 8'b00000011, 8'b00000010,
                8'b00001000, 8'b00000000, 8'b00000000, 8'b00000000, 8'b00001000};
    vecs[2] = '{5'b00011, 1'b0, 1'b0, 1'b1, 5, 8'b00000011, 8'b00000010,
                8'b00001000, 8'b00000000, 8'b00000000, 8'b00010000, 8'b00010000};
    vecs[3] = '{5'b00101, 1'b1, 1'b0, 1'b1, 7, 8'b00000011, 8'b00000010,
                8'b00001000, 8'b00110000, 8'b00000000, 8'b01000000, 8'b01000000};
    vecs[4] = '{5'b00110, 1'b0, 1'b1, 1'b0, 5, 8'b00000011, 8'b00000010,
                8'b00001000, 8'b00010000, 8'b00010000, 8'b00000000, 8'b00010000};

    // Reset state.
    applyStimulus(5'b00000, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("resetOutputs", {23'd0, outVec()}, 32'd0);
    checkOutput("resetCycleCnt", cycleCnt, 32'd0);
    checkOutput("resetInstrCnt", instrCnt, 32'd0);
    tick();
    checkOutput("idleStays", {23'd0, outVec()}, 32'd0);

    // Table-driven instruction classes under run=1.
    for (int v = 0; v < 5; v++) begin
      applyStimulus(vecs[v].op, vecs[v].mr, vecs[v].mw, vecs[v].rw, 1'b1);
      waitFetch($sformatf("v%0d fetchTimeout", v));
      for (int c = 0; c < vecs[v].lat; c++) begin
        exp = {vecs[v].imemMask[c], vecs[v].irMask[c], vecs[v].aluMask[c],
               vecs[v].dmemEnMask[c], vecs[v].dmemWeMask[c], vecs[v].rfWeMask[c],
               vecs[v].pcWeMask[c], vecs[v].pcWeMask[c], 1'b0};
        checkOutput($sformatf("v%0d cycle%0d outputs", v, c + 1),
                    {23'd0, outVec()}, {23'd0, exp});
        tick();
      end
      checkOutput($sformatf("v%0d cycleCnt", v), cycleCnt, vecs[v].lat);
      checkOutput($sformatf("v%0d instrCnt", v), instrCnt, 32'd1);
      checkOutput($sformatf("v%0d refetch", v), {31'd0, imemEn}, 32'd1);
    end

    // Single step: pulses at k and k+2; the second lands mid-instruction.
    applyStimulus(5'b00001, 1'b0, 1'b0, 1'b1, 1'b0);
    retires = 0;
    for (int i = 0; i < 25; i++) begin
      stepReq = (i == 0 || i == 2);
      if (retire) retires++;
      tick();
    end
    stepReq = 1'b0;
    checkOutput("stepRetires", retires, 32'd1);
    checkOutput("stepInstrCnt", instrCnt, 32'd1);
    checkOutput("stepCycleCnt", cycleCnt, 32'd5);
    checkOutput("stepIdle", {23'd0, outVec()}, 32'd0);

    // Back-to-back step pulses: the second is dropped while the token is held.
    applyStimulus(5'b00001, 1'b0, 1'b0, 1'b0, 1'b0);
    retires = 0;
    for (int i = 0; i < 20; i++) begin
      stepReq = (i == 0 || i == 1);
      if (retire) retires++;
      tick();
    end
    stepReq = 1'b0;
    checkOutput("stepAdjRetires", retires, 32'd1);
    checkOutput("stepAdjInstrCnt", instrCnt, 32'd1);

    // Halt opcode.
    applyStimulus(5'b11111, 1'b0, 1'b0, 1'b1, 1'b1);
    waitFetch("haltFetchTimeout");
    tick();
    tick();
    tick();
    checkOutput("haltEntered", {31'd0, halted}, 32'd1);
    checkOutput("haltCycleCnt", cycleCnt, 32'd3);
    pcSeen = 0;
    for (int i = 0; i < 20; i++) begin
      if (pcWe || retire || imemEn || !halted) pcSeen++;
      tick();
    end
    checkOutput("haltAbsorbing", pcSeen, 32'd0);
    checkOutput("haltCycleFrozen", cycleCnt, 32'd3);
    checkOutput("haltInstrFrozen", instrCnt, 32'd0);
    applyStimulus(5'b00000, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("haltResetOutputs", {23'd0, outVec()}, 32'd0);
    checkOutput("haltResetCycleCnt", cycleCnt, 32'd0);
    tick();
    checkOutput("haltResetIdle", {23'd0, outVec()}, 32'd0);

    // Clearing run mid-instruction completes it and parks in IDLE.
    applyStimulus(5'b00010, 1'b0, 1'b0, 1'b1, 1'b1);
    waitFetch("runClrFetchTimeout");
    run = 1'b0;
    tick();
    tick();
    tick();
    tick();
    checkOutput("runClrRetire", {30'd0, pcWe, retire}, 32'd3);
    tick();
    checkOutput("runClrInstrCnt", instrCnt, 32'd1);
    tick();
    checkOutput("runClrIdle", {23'd0, outVec()}, 32'd0);

    // Reset while a store sits in MEM.
    applyStimulus(5'b00110, 1'b0, 1'b1, 1'b0, 1'b1);
    waitFetch("rstMemFetchTimeout");
    tick();
    tick();
    tick();
    tick();
    checkOutput("rstMemStoreWe", {31'd0, dmemWe}, 32'd1);
    reset = 1'b1;
    tick();
    checkOutput("rstMemOutputs", {23'd0, outVec()}, 32'd0);
    checkOutput("rstMemCycleCnt", cycleCnt, 32'd0);
    checkOutput("rstMemInstrCnt", instrCnt, 32'd0);
    reset = 1'b0;
    run   = 1'b0;
    tick();
    checkOutput("rstMemIdle", {23'd0, outVec()}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
